// File: rtl/free_list_controller_pkg.sv
// Shared definitions for the free-list controller slice.
// Holds the FSM state encoding, the default position-iterator width and the
// column-field width. Both widths must match the redundancy checker.
package free_list_controller_pkg;

   // Position iterator: upper bits are the row, lower COL_WIDTH bits the column.
   localparam int ITER_WIDTH_DEF = 9;
   localparam int COL_WIDTH      = 7;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_DRAIN   = 2'd2,
      ST_DONE    = 2'd3
   } fl_state_e;

endpackage

// File: rtl/free_list_controller_if.sv
// Move-command channel from the free-list controller to the LIFM/table writer.
// Ports: mv_valid/mv_src/mv_dest driven by the master (controller),
//        mv_ready driven by the slave (write-back consumer).
interface free_list_controller_if import free_list_controller_pkg::*;
   #(parameter int ITER_WIDTH = ITER_WIDTH_DEF);

   logic                  mv_valid;
   logic                  mv_ready;
   logic [ITER_WIDTH-1:0] mv_src;
   logic [ITER_WIDTH-1:0] mv_dest;

   modport master (output mv_valid, output mv_src, output mv_dest, input mv_ready);
   modport slave  (input mv_valid, input mv_src, input mv_dest, output mv_ready);

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count.
// Ports: clk, reset_n (async active-low), clr (sync clear), push/din,
//        pop/dout (head is visible on dout while not empty), count, full, empty.
// A push into a full FIFO and a pop from an empty FIFO are ignored.
// Push and pop in the same cycle are both honoured.
module sync_fifo #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 16,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clr,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic [CW-1:0]    count,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [CW-1:0]    count_r;
   logic             push_ok_s;
   logic             pop_ok_s;

   // Full/empty come from the count so a wrapped pointer pair is unambiguous.
   assign full      = (count_r == CNT_FULL);
   assign empty     = (count_r == {CW{1'b0}});
   assign push_ok_s = push & ~full;
   assign pop_ok_s  = pop & ~empty;
   assign dout      = mem_r[rd_ptr_r];
   assign count     = count_r;

   // Storage write; contents are don't-care while the count says empty.
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_r[wr_ptr_r] <= din;
      end
   end

   // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else if (clr) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else begin
         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_r <= count_r + CNT_ONE;
            2'b01:   count_r <= count_r - CNT_ONE;
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/free_list_controller.sv
// Free-list controller: receiving end of the redundancy checker.
// Collects freed positions (free list) and no-redundancy positions in two
// FIFOs during a pass; after rch_done, pairs them into compaction moves
// (src = nr position, dest = free position) for the write-back logic.
// Ports: clk, reset_n (async), set_idle (sync return to IDLE), start,
//        fl_valid/fl_in, nr_valid/nr_in, rch_done from the checker,
//        mv (move channel, master side), fl_count, overflow (sticky), done.
module free_list_controller import free_list_controller_pkg::*; #(
   parameter int ITER_WIDTH = ITER_WIDTH_DEF,
   parameter int FL_DEPTH   = 16,
   parameter int NR_DEPTH   = 16,
   parameter int CNT_WIDTH  = 5
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  set_idle,
   input  logic                  start,
   input  logic                  fl_valid,
   input  logic [ITER_WIDTH-1:0] fl_in,
   input  logic                  nr_valid,
   input  logic [ITER_WIDTH-1:0] nr_in,
   input  logic                  rch_done,
   free_list_controller_if.master mv,
   output logic [CNT_WIDTH-1:0]  fl_count,
   output logic                  overflow,
   output logic                  done
);

   fl_state_e             state_r;
   logic                  mv_valid_r;
   logic [ITER_WIDTH-1:0] mv_src_r;
   logic [ITER_WIDTH-1:0] mv_dest_r;
   logic                  overflow_r;
   logic                  done_r;

   logic                  collect_s;
   logic                  fl_push_s;
   logic                  nr_push_s;
   logic                  fl_pop_s;
   logic                  nr_pop_s;
   logic [ITER_WIDTH-1:0] fl_head_s;
   logic [ITER_WIDTH-1:0] nr_head_s;
   logic                  fl_full_s;
   logic                  nr_full_s;
   logic                  fl_empty_s;
   logic                  nr_empty_s;
   logic [CNT_WIDTH-1:0]  nr_count_unused_s;
   logic                  drop_s;
   logic                  pair_empty_s;

   // Pushes are only taken while collecting; set_idle overrides everything.
   assign collect_s    = (state_r == ST_COLLECT) & ~set_idle;
   assign fl_push_s    = collect_s & fl_valid;
   assign nr_push_s    = collect_s & nr_valid;
   assign drop_s       = (fl_push_s & fl_full_s) | (nr_push_s & nr_full_s);
   assign pair_empty_s = fl_empty_s | nr_empty_s;

   sync_fifo #(.WIDTH(ITER_WIDTH), .DEPTH(FL_DEPTH), .CW(CNT_WIDTH)) u_fl_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (set_idle),
      .push    (fl_push_s),
      .pop     (fl_pop_s),
      .din     (fl_in),
      .dout    (fl_head_s),
      .count   (fl_count),
      .full    (fl_full_s),
      .empty   (fl_empty_s)
   );

   sync_fifo #(.WIDTH(ITER_WIDTH), .DEPTH(NR_DEPTH), .CW(CNT_WIDTH)) u_nr_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (set_idle),
      .push    (nr_push_s),
      .pop     (nr_pop_s),
      .din     (nr_in),
      .dout    (nr_head_s),
      .count   (nr_count_unused_s),
      .full    (nr_full_s),
      .empty   (nr_empty_s)
   );

   // Drain pops: both heads on a move handshake, nr head alone when that
   // element already sits before the hole (nr_h <= fl_h).
   always_comb begin
      fl_pop_s = 1'b0;
      nr_pop_s = 1'b0;
      if ((state_r == ST_DRAIN) && !set_idle) begin
         if (mv_valid_r) begin
            if (mv.mv_ready) begin
               fl_pop_s = 1'b1;
               nr_pop_s = 1'b1;
            end else begin
               fl_pop_s = 1'b0;
            end
         end else if (!pair_empty_s && !(nr_head_s > fl_head_s)) begin
            nr_pop_s = 1'b1;
         end else begin
            nr_pop_s = 1'b0;
         end
      end else begin
         fl_pop_s = 1'b0;
      end
   end

   // Control FSM with registered move command and status flags.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r    <= ST_IDLE;
         mv_valid_r <= 1'b0;
         mv_src_r   <= {ITER_WIDTH{1'b0}};
         mv_dest_r  <= {ITER_WIDTH{1'b0}};
         overflow_r <= 1'b0;
         done_r     <= 1'b0;
      end else if (set_idle) begin
         state_r    <= ST_IDLE;
         mv_valid_r <= 1'b0;
         mv_src_r   <= {ITER_WIDTH{1'b0}};
         mv_dest_r  <= {ITER_WIDTH{1'b0}};
         overflow_r <= 1'b0;
         done_r     <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  state_r <= ST_COLLECT;
               end
            end
            ST_COLLECT: begin
               if (drop_s) begin
                  overflow_r <= 1'b1;
               end
               if (rch_done) begin
                  state_r <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (mv_valid_r) begin
                  // Command held stable until accepted.
                  if (mv.mv_ready) begin
                     mv_valid_r <= 1'b0;
                  end
               end else if (pair_empty_s) begin
                  state_r <= ST_DONE;
                  done_r  <= 1'b1;
               end else if (nr_head_s > fl_head_s) begin
                  mv_valid_r <= 1'b1;
                  mv_src_r   <= nr_head_s;
                  mv_dest_r  <= fl_head_s;
               end
            end
            ST_DONE: begin
               done_r <= 1'b1;
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign mv.mv_valid = mv_valid_r;
   assign mv.mv_src   = mv_src_r;
   assign mv.mv_dest  = mv_dest_r;
   assign overflow    = overflow_r;
   assign done        = done_r;

endmodule

// File: tb/tb_free_list_controller.sv
// Directed self-checking bench for free_list_controller.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_free_list_controller;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       set_idle;
   logic       start;
   logic       fl_valid;
   logic [8:0] fl_in;
   logic       nr_valid;
   logic [8:0] nr_in;
   logic       rch_done;
   logic [4:0] fl_count;
   logic       overflow;
   logic       done;

   int total = 0;
   int bad   = 0;

   logic [8:0] src_q[$];
   logic [8:0] dest_q[$];

   free_list_controller_if #(.ITER_WIDTH(9)) mv_if ();

   free_list_controller #(
      .ITER_WIDTH (9),
      .FL_DEPTH   (16),
      .NR_DEPTH   (16),
      .CNT_WIDTH  (5)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .set_idle (set_idle),
      .start    (start),
      .fl_valid (fl_valid),
      .fl_in    (fl_in),
      .nr_valid (nr_valid),
      .nr_in    (nr_in),
      .rch_done (rch_done),
      .mv       (mv_if.master),
      .fl_count (fl_count),
      .overflow (overflow),
      .done     (done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
   endtask

   // Present one cycle of checker traffic.
   task automatic drive(input bit fv, input logic [8:0] f, input bit nv,
                        input logic [8:0] n, input bit rd);
      fl_valid = fv; fl_in = f; nr_valid = nv; nr_in = n; rch_done = rd;
      tick();
      fl_valid = 1'b0; nr_valid = 1'b0; rch_done = 1'b0;
   endtask

   // Return to IDLE, then enter COLLECT.
   task automatic start_pass();
      set_idle = 1'b1;
      tick();
      set_idle = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Run the drain with mv_ready high, logging handshakes until done.
   task automatic run_drain(input int max_cycles, output int moves, output bit timed_out);
      moves = 0;
      timed_out = 1'b1;
      src_q.delete();
      dest_q.delete();
      mv_if.mv_ready = 1'b1;
      for (int i = 0; i < max_cycles; i++) begin
         if (done === 1'b1) begin
            timed_out = 1'b0;
            break;
         end
         if (mv_if.mv_valid === 1'b1) begin
            moves++;
            src_q.push_back(mv_if.mv_src);
            dest_q.push_back(mv_if.mv_dest);
         end
         tick();
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0; set_idle = 1'b0; start = 1'b0; rch_done = 1'b0;
      fl_valid = 1'b0; fl_in = 9'd0; nr_valid = 1'b0; nr_in = 9'd0;
      mv_if.mv_ready = 1'b0;
      tick(); tick();
      total++; if (mv_if.mv_valid !== 1'b0) begin bad++; $display("FAIL reset_mv_valid got=%b exp=0", mv_if.mv_valid); end
      total++; if (mv_if.mv_src !== 9'd0) begin bad++; $display("FAIL reset_mv_src got=%0d exp=0", mv_if.mv_src); end
      total++; if (mv_if.mv_dest !== 9'd0) begin bad++; $display("FAIL reset_mv_dest got=%0d exp=0", mv_if.mv_dest); end
      total++; if (fl_count !== 5'd0) begin bad++; $display("FAIL reset_fl_count got=%0d exp=0", fl_count); end
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
      reset_n = 1'b1;
      tick();
      // IDLE ignores pushes.
      drive(1'b1, 9'd7, 1'b1, 9'd8, 1'b0);
      total++; if (fl_count !== 5'd0) begin bad++; $display("FAIL idle_push_ignored got=%0d exp=0", fl_count); end
   endtask

   task automatic test_basic_pair();
      int moves; bit to;
      start_pass();
      drive(1'b1, 9'd5, 1'b1, 9'd130, 1'b0);
      total++; if (fl_count !== 5'd1) begin bad++; $display("FAIL basic_collect_count got=%0d exp=1", fl_count); end
      drive(1'b0, 9'd0, 1'b0, 9'd0, 1'b1);
      run_drain(40, moves, to);
      total++; if (to !== 1'b0) begin bad++; $display("FAIL basic_timeout got=%b exp=0", to); end
      total++; if (moves !== 1) begin bad++; $display("FAIL basic_moves got=%0d exp=1", moves); end
      if (moves >= 1) begin
         total++; if (src_q[0] !== 9'd130 || dest_q[0] !== 9'd5) begin bad++; $display("FAIL basic_move got=%0d->%0d exp=130->5", src_q[0], dest_q[0]); end
      end
      total++; if (done !== 1'b1) begin bad++; $display("FAIL basic_done got=%b exp=1", done); end
      total++; if (fl_count !== 5'd0) begin bad++; $display("FAIL basic_fl_count got=%0d exp=0", fl_count); end
   endtask

   task automatic test_skip();
      int moves; bit to;
      start_pass();
      drive(1'b1, 9'd200, 1'b1, 9'd3, 1'b0);
      drive(1'b0, 9'd0, 1'b0, 9'd0, 1'b1);
      run_drain(40, moves, to);
      total++; if (to !== 1'b0) begin bad++; $display("FAIL skip_timeout got=%b exp=0", to); end
      total++; if (moves !== 0) begin bad++; $display("FAIL skip_moves got=%0d exp=0", moves); end
      total++; if (done !== 1'b1) begin bad++; $display("FAIL skip_done got=%b exp=1", done); end
      total++; if (fl_count !== 5'd1) begin bad++; $display("FAIL skip_fl_count got=%0d exp=1", fl_count); end
      tick(); tick();
      total++; if (done !== 1'b1 || fl_count !== 5'd1) begin bad++; $display("FAIL skip_done_hold got=%b/%0d exp=1/1", done, fl_count); end
   endtask

   task automatic test_backpressure();
      int moves; bit to; bit seen;
      seen = 1'b0;
      start_pass();
      mv_if.mv_ready = 1'b0;
      drive(1'b1, 9'd5, 1'b1, 9'd130, 1'b0);
      drive(1'b0, 9'd0, 1'b0, 9'd0, 1'b1);
      for (int i = 0; i < 10; i++) begin
         if (mv_if.mv_valid === 1'b1) begin seen = 1'b1; break; end
         tick();
      end
      total++; if (seen !== 1'b1) begin bad++; $display("FAIL bp_valid_timeout got=%b exp=1", seen); end
      for (int c = 0; c < 4; c++) begin
         total++;
         if (mv_if.mv_valid !== 1'b1 || mv_if.mv_src !== 9'd130 || mv_if.mv_dest !== 9'd5) begin
            bad++;
            $display("FAIL bp_hold_%0d got=%b %0d->%0d exp=1 130->5", c, mv_if.mv_valid, mv_if.mv_src, mv_if.mv_dest);
         end
         tick();
      end
      total++; if (fl_count !== 5'd1) begin bad++; $display("FAIL bp_no_pop got=%0d exp=1", fl_count); end
      mv_if.mv_ready = 1'b1;
      tick();
      total++; if (mv_if.mv_valid !== 1'b0 || fl_count !== 5'd0) begin bad++; $display("FAIL bp_handshake got=%b/%0d exp=0/0", mv_if.mv_valid, fl_count); end
      run_drain(40, moves, to);
      total++; if (to !== 1'b0 || moves !== 0) begin bad++; $display("FAIL bp_extra_moves got=%0d to=%b exp=0 to=0", moves, to); end
   endtask

   task automatic test_overflow();
      int moves; bit to; bit hit;
      hit = 1'b0;
      start_pass();
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, 9'(i), 1'b1, 9'(300 + i), 1'b0);
      end
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_early got=%b exp=0", overflow); end
      drive(1'b1, 9'd16, 1'b0, 9'd0, 1'b0);
      total++; if (fl_count !== 5'd16) begin bad++; $display("FAIL ovf_fl_count got=%0d exp=16", fl_count); end
      total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
      drive(1'b0, 9'd0, 1'b0, 9'd0, 1'b1);
      run_drain(200, moves, to);
      total++; if (to !== 1'b0 || moves !== 16) begin bad++; $display("FAIL ovf_moves got=%0d to=%b exp=16 to=0", moves, to); end
      foreach (dest_q[k]) begin
         if (dest_q[k] === 9'd16) hit = 1'b1;
      end
      total++; if (hit !== 1'b0) begin bad++; $display("FAIL ovf_dropped_dest got=%b exp=0", hit); end
      if (moves == 16) begin
         total++; if (src_q[15] !== 9'd315 || dest_q[15] !== 9'd15) begin bad++; $display("FAIL ovf_last_move got=%0d->%0d exp=315->15", src_q[15], dest_q[15]); end
      end
      total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
   endtask

   task automatic test_simultaneous();
      int moves; bit to;
      start_pass();
      drive(1'b1, 9'd1, 1'b1, 9'd9, 1'b1);
      total++; if (fl_count !== 5'd1) begin bad++; $display("FAIL sim_accept got=%0d exp=1", fl_count); end
      run_drain(40, moves, to);
      total++; if (to !== 1'b0 || moves !== 1) begin bad++; $display("FAIL sim_moves got=%0d to=%b exp=1 to=0", moves, to); end
      if (moves >= 1) begin
         total++; if (src_q[0] !== 9'd9 || dest_q[0] !== 9'd1) begin bad++; $display("FAIL sim_move got=%0d->%0d exp=9->1", src_q[0], dest_q[0]); end
      end
   endtask

   // Bring the block to DRAIN with a pending move, overflow set, ready low.
   task automatic setup_pending(output bit seen);
      seen = 1'b0;
      start_pass();
      mv_if.mv_ready = 1'b0;
      for (int i = 0; i < 17; i++) begin
         drive(1'b1, 9'(i), 1'b1, 9'(400 + i), 1'b0);
      end
      drive(1'b0, 9'd0, 1'b0, 9'd0, 1'b1);
      for (int i = 0; i < 10; i++) begin
         if (mv_if.mv_valid === 1'b1) begin seen = 1'b1; break; end
         tick();
      end
   endtask

   task automatic test_idle_reset();
      bit seen;
      setup_pending(seen);
      total++; if (seen !== 1'b1 || overflow !== 1'b1) begin bad++; $display("FAIL idle_setup got=%b/%b exp=1/1", seen, overflow); end
      set_idle = 1'b1;
      tick();
      set_idle = 1'b0;
      total++; if (mv_if.mv_valid !== 1'b0 || done !== 1'b0 || overflow !== 1'b0 || fl_count !== 5'd0) begin
         bad++; $display("FAIL set_idle_clear got=v%b d%b o%b c%0d exp=v0 d0 o0 c0", mv_if.mv_valid, done, overflow, fl_count);
      end
      drive(1'b1, 9'd3, 1'b1, 9'd4, 1'b0);
      total++; if (fl_count !== 5'd0) begin bad++; $display("FAIL set_idle_state got=%0d exp=0", fl_count); end

      setup_pending(seen);
      total++; if (seen !== 1'b1) begin bad++; $display("FAIL rst_setup got=%b exp=1", seen); end
      reset_n = 1'b0;
      #1;
      total++; if (mv_if.mv_valid !== 1'b0 || done !== 1'b0 || overflow !== 1'b0 || fl_count !== 5'd0) begin
         bad++; $display("FAIL async_rst_clear got=v%b d%b o%b c%0d exp=v0 d0 o0 c0", mv_if.mv_valid, done, overflow, fl_count);
      end
      tick();
      reset_n = 1'b1;
      tick();
      drive(1'b1, 9'd3, 1'b1, 9'd4, 1'b0);
      total++; if (fl_count !== 5'd0 || mv_if.mv_valid !== 1'b0) begin bad++; $display("FAIL async_rst_state got=%0d/%b exp=0/0", fl_count, mv_if.mv_valid); end
   endtask

   initial begin
      test_reset();
      test_basic_pair();
      test_skip();
      test_backpressure();
      test_overflow();
      test_simultaneous();
      test_idle_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/free_list_controller.md
Name: free_list_controller

Overview:
- Receiving end of the redundancy checker's free-list interface.
- Collects freed positions (free-list entries) and no-redundancy positions from the checker during a pass, each into its own FIFO.
- After the checker reports done, pairs the two streams into compaction move commands (src=nr position, dest=free position) for the LIFM/table writer.
- Sits between the redundancy checker and the buffer write-back logic.

Parameters:
ITER_WIDTH, 9, position iterator width (upper bits row, lower 7 bits column); must match the checker
FL_DEPTH, 16, free-list FIFO depth (power of two)
NR_DEPTH, 16, no-redundancy FIFO depth (power of two)
CNT_WIDTH, 5, occupancy counter width; must equal log2(max(FL_DEPTH,NR_DEPTH))+1

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous active-low reset
set_idle  input  1  synchronous return to IDLE; clears FIFOs and flags
start  input  1  begin collection (IDLE->COLLECT)
fl_valid  input  1  free-list entry valid (checker valid_fl)
fl_in  input  ITER_WIDTH  freed position (checker fl_out)
nr_valid  input  1  no-redundancy entry valid
nr_in  input  ITER_WIDTH  no-redundancy position (checker nr_out)
rch_done  input  1  checker finished the pass
mv_valid  output  1  move command valid
mv_ready  input  1  consumer accepts move
mv_src  output  ITER_WIDTH  position to read from
mv_dest  output  ITER_WIDTH  position to write to
fl_count  output  CNT_WIDTH  current free-list FIFO occupancy
overflow  output  1  sticky: a push was dropped because its FIFO was full
done  output  1  pairing complete; held until set_idle

Behaviour:
- Reset: state IDLE. Both FIFO pointers and counts 0. mv_valid=0, mv_src=0, mv_dest=0, fl_count=0, overflow=0, done=0.
- set_idle has priority over every other input:
  - Next cycle: state IDLE, FIFOs emptied, overflow=0, done=0, mv_valid=0.
- States are IDLE, COLLECT, DRAIN, DONE:
  - IDLE: all pushes ignored. start -> COLLECT.
  - COLLECT:
    - fl_valid pushes fl_in; nr_valid pushes nr_in. Independent FIFOs; both may push in the same cycle.
    - Push into a full FIFO: entry dropped, overflow set; other FIFO unaffected.
    - rch_done -> DRAIN. A push asserted in the same cycle as rch_done is still accepted.
  - DRAIN:
    - Pushes ignored.
    - Either FIFO empty and mv_valid=0 -> DONE.
    - Otherwise evaluate the heads, fl_h and nr_h, with an unsigned compare:
      - nr_h > fl_h: register mv_src=nr_h, mv_dest=fl_h, mv_valid=1 one cycle after evaluation. Hold all three stable until the mv_valid&&mv_ready cycle. In that cycle pop both heads and drop mv_valid. The next head pair is evaluated the following cycle, so throughput is one move per 2 cycles.
      - nr_h <= fl_h: element is already before the hole. Pop the nr head only; no move issued; 1 cycle.
    - mv_ready is ignored while mv_valid=0.
  - DONE: done=1; remaining free-list entries stay counted in fl_count. Leave only via set_idle.
- fl_count tracks the free-list FIFO occupancy every cycle, registered.
- Pointers wrap modulo depth. Full/empty are derived from the count, never from a pointer compare alone.
- An asynchronous reset mid-operation abandons any pending move: mv_valid drops immediately.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE=0, COLLECT=1, DRAIN=2, DONE=3);
  - ITER_WIDTH default;
  - the column-field width constant (7) shared with the checker.
- One sub-module, sync_fifo (params WIDTH, DEPTH; ports push, pop, din, dout, count, full, empty).
  - Instantiated twice: free-list FIFO and nr FIFO.
  - Pop and push in the same cycle are allowed.
  - Push when full is rejected inside the FIFO; the top level raises overflow.

Test Plan:
- Basic pair:
  - Stimulus: start; fl_in=5; nr_in=130; rch_done; mv_ready=1.
  - Response: one move mv_src=130, mv_dest=5; both FIFOs empty; done=1; fl_count=0.
- Skip:
  - Stimulus: fl_in=200; nr_in=3; rch_done.
  - Response: no mv_valid; nr entry popped; done=1; fl_count=1.
- Backpressure:
  - Stimulus: as the basic pair, with mv_ready=0 for 4 cycles.
  - Response: mv_valid/mv_src/mv_dest stable all 4 cycles; single handshake when mv_ready rises; exactly one move.
- Overflow:
  - Stimulus: 17 fl pushes with FL_DEPTH=16.
  - Response: fl_count=16; overflow=1; the 17th value never appears as mv_dest.
- Simultaneous:
  - Stimulus: fl_valid and nr_valid in the same cycle as rch_done (fl=1, nr=9).
  - Response: both accepted; move 9->1 issued.
- Reset/idle:
  - Stimulus: set_idle while mv_valid=1; separately, reset_n low mid-DRAIN.
  - Response: next cycle (set_idle) or immediately (reset_n) mv_valid=0, done=0, overflow=0, fl_count=0, state IDLE.
